// File: rtl/fifo_arb_pkg.sv
// Shared types for the fifo write-port arbiter.
package fifo_arb_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    OWN  = 1'b1
  } arb_state_e;

endpackage

// File: rtl/fifo_arbiter_rr_pick.sv
// Combinational round-robin selector: first set request strictly after ptr,
// wrapping; the request at ptr itself is considered last.
module rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] idx,
  output logic                 any
);

  localparam int IW = $clog2(N);

  logic [IW-1:0] cand_s;

  // Scan ptr+1 .. ptr+N; N is a power of two so the truncating add wraps.
  always_comb begin
    gnt    = '0;
    idx    = '0;
    any    = 1'b0;
    cand_s = '0;
    for (int k = 1; k <= N; k++) begin
      cand_s = ptr + IW'(k);
      if (req[cand_s] && !any) begin
        any         = 1'b1;
        idx         = cand_s;
        gnt[cand_s] = 1'b1;
      end else begin
        any = any;
      end
    end
  end

endmodule

// File: rtl/fifo_arbiter.sv
// Round-robin arbiter sharing one fifo write port among NUM_REQ requesters,
// with bursts of up to MAX_BURST beats per grant.
module fifo_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*WIDTH-1:0]   req_data,
  input  logic [NUM_REQ-1:0]         req_last,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       fifo_wr_en,
  output logic [WIDTH-1:0]           fifo_din,
  input  logic                       fifo_full,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       busy
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(MAX_BURST + 1);

  arb_state_e         state_r, state_s;
  logic [IW-1:0]      owner_r, owner_s;
  logic [NUM_REQ-1:0] owner_oh_r, owner_oh_s;
  logic [CW-1:0]      beat_cnt_r, beat_cnt_s;
  logic [IW-1:0]      rr_ptr_r, rr_ptr_s;

  logic [NUM_REQ-1:0] pick_gnt_s;
  logic [IW-1:0]      pick_idx_s;
  logic               pick_any_s;
  logic               owner_valid_s;
  logic               owner_last_s;
  logic               beat_s;

  rr_pick #(.N(NUM_REQ)) u_rr_pick (
    .req (req_valid),
    .ptr (rr_ptr_r),
    .gnt (pick_gnt_s),
    .idx (pick_idx_s),
    .any (pick_any_s)
  );

  assign owner_valid_s = req_valid[owner_r];
  assign owner_last_s  = req_last[owner_r];

  // State and arbitration registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      owner_r    <= '0;
      owner_oh_r <= '0;
      beat_cnt_r <= '0;
      rr_ptr_r   <= IW'(NUM_REQ - 1);
    end else begin
      state_r    <= state_s;
      owner_r    <= owner_s;
      owner_oh_r <= owner_oh_s;
      beat_cnt_r <= beat_cnt_s;
      rr_ptr_r   <= rr_ptr_r == rr_ptr_s ? rr_ptr_r : rr_ptr_s;
    end
  end

  // Next-state: grant in IDLE, count beats and release in OWN.
  always_comb begin
    state_s    = state_r;
    owner_s    = owner_r;
    owner_oh_s = owner_oh_r;
    beat_cnt_s = beat_cnt_r;
    rr_ptr_s   = rr_ptr_r;
    beat_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (pick_any_s) begin
          state_s    = OWN;
          owner_s    = pick_idx_s;
          owner_oh_s = pick_gnt_s;
          beat_cnt_s = '0;
        end else begin
          state_s = IDLE;
        end
      end
      OWN: begin
        beat_s = owner_valid_s && !fifo_full;
        if (beat_s) begin
          beat_cnt_s = beat_cnt_r + CW'(1);
          if (owner_last_s || (beat_cnt_s == CW'(MAX_BURST))) begin
            state_s  = IDLE;
            rr_ptr_s = owner_r;
          end else begin
            state_s = OWN;
          end
        end else if (!owner_valid_s) begin
          // A dropped valid releases the grant even while the fifo is full.
          state_s  = IDLE;
          rr_ptr_s = owner_r;
        end else begin
          state_s = OWN;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  assign req_ready  = ((state_r == OWN) && !fifo_full && !rst) ? owner_oh_r : '0;
  assign fifo_wr_en = beat_s && !rst;
  assign fifo_din   = req_data[owner_r*WIDTH +: WIDTH];
  assign grant_id   = owner_r;
  assign busy       = (state_r == OWN);

endmodule

// File: tb/tb_fifo_arbiter.sv
// Randomized bench for fifo_arbiter against a cycle-level behavioural model.
module tb_fifo_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int MB = 4;
  localparam int NPH = 5;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_last;
  logic [N-1:0]   req_ready;
  logic           fifo_wr_en;
  logic [W-1:0]   fifo_din;
  logic           fifo_full;
  logic [1:0]     grant_id;
  logic           busy;

  always #5 clk = ~clk;

  fifo_arbiter #(.NUM_REQ(N), .WIDTH(W), .MAX_BURST(MB)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_last   (req_last),
    .req_ready  (req_ready),
    .fifo_wr_en (fifo_wr_en),
    .fifo_din   (fifo_din),
    .fifo_full  (fifo_full),
    .grant_id   (grant_id),
    .busy       (busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: who owns the port, beats so far, last released owner.
  bit           m_own;
  int           m_owner;
  int           m_cnt;
  int           m_ptr;
  logic [W-1:0] cur_data [N];
  logic [N-1:0] acc_mask;
  int           cyc;
  int           wr_ids [$];
  int           wr_cyc [$];

  int ph_cycles [NPH] = '{12, 16, 40, 60, 400};
  int ph_mask   [NPH] = '{15, 4, 15, 15, 15};
  int ph_pv     [NPH] = '{100, 100, 100, 70, 80};
  int ph_plast  [NPH] = '{100, 0, 0, 30, 25};
  int ph_pfull  [NPH] = '{0, 0, 40, 20, 25};
  int ph_prst   [NPH] = '{0, 0, 0, 0, 4};

  task automatic model_reset();
    m_own   = 1'b0;
    m_owner = 0;
    m_cnt   = 0;
    m_ptr   = N - 1;
  endtask

  task automatic drive(input int p);
    for (int i = 0; i < N; i++) begin
      if (acc_mask[i]) cur_data[i] = W'($urandom);
      req_valid[i]         = ph_mask[p][i] && ($urandom_range(0, 99) < ph_pv[p]);
      req_last[i]          = $urandom_range(0, 99) < ph_plast[p];
      req_data[i*W +: W]   = cur_data[i];
    end
    fifo_full = $urandom_range(0, 99) < ph_pfull[p];
  endtask

  task automatic eval_cycle(input bit record);
    logic [N-1:0] e_ready;
    bit           e_wr;
    if (rst) model_reset();
    e_wr    = m_own && req_valid[m_owner] && !fifo_full && !rst;
    e_ready = (m_own && !fifo_full && !rst) ? (N'(1) << m_owner) : '0;
    check_eq("req_ready", 32'(req_ready), 32'(e_ready));
    check_eq("fifo_wr_en", 32'(fifo_wr_en), 32'(e_wr));
    check_eq("busy", 32'(busy), 32'(m_own));
    check_eq("grant_id", 32'(grant_id), 32'(m_owner));
    check_eq("wr_while_full", 32'(fifo_wr_en & fifo_full), 32'd0);
    if (e_wr) check_eq("fifo_din", 32'(fifo_din), 32'(cur_data[m_owner]));
    if (record && fifo_wr_en) begin
      wr_ids.push_back(int'(grant_id));
      wr_cyc.push_back(cyc);
    end
    acc_mask = e_wr ? (N'(1) << m_owner) : '0;
    if (!rst) begin
      if (!m_own) begin
        if (req_valid != '0) begin
          for (int k = 1; k <= N; k++) begin
            int j;
            j = (m_ptr + k) % N;
            if (req_valid[j]) begin
              m_owner = j;
              break;
            end
          end
          m_cnt = 0;
          m_own = 1'b1;
        end
      end else if (e_wr) begin
        m_cnt++;
        if (req_last[m_owner] || m_cnt == MB) begin
          m_own = 1'b0;
          m_ptr = m_owner;
        end
      end else if (!req_valid[m_owner]) begin
        m_own = 1'b0;
        m_ptr = m_owner;
      end
    end
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    fifo_full = 1'b0;
    acc_mask  = '0;
    cyc       = 0;
    for (int i = 0; i < N; i++) cur_data[i] = W'($urandom);
    model_reset();

    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_ready", 32'(req_ready), 32'd0);
    check_eq("rst_wr_en", 32'(fifo_wr_en), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_grant_id", 32'(grant_id), 32'd0);
    rst = 1'b0;

    for (int p = 0; p < NPH; p++) begin
      for (int c = 0; c < ph_cycles[p]; c++) begin
        @(posedge clk);
        #1;
        if (rst) rst = 1'b0;
        drive(p);
        if (ph_prst[p] > 0 && m_own && ($urandom_range(0, 99) < ph_prst[p])) begin
          #2 rst = 1'b1;
          #1;
          check_eq("midrst_ready", 32'(req_ready), 32'd0);
          check_eq("midrst_wr_en", 32'(fifo_wr_en), 32'd0);
          check_eq("midrst_busy", 32'(busy), 32'd0);
          check_eq("midrst_grant_id", 32'(grant_id), 32'd0);
        end
        @(negedge clk);
        eval_cycle(p == 0);
        cyc++;
      end
      if (p == 0) begin
        // All requesters valid with last on every beat: 0,1,2,3,0, one idle between.
        check_eq("rr_grant_count", 32'(wr_ids.size() >= 5), 32'd1);
        if (wr_ids.size() >= 5) begin
          for (int k = 0; k < 5; k++) check_eq("rr_grant_order", 32'(wr_ids[k]), 32'(k % N));
          for (int k = 0; k < 4; k++) check_eq("rr_idle_gap", 32'(wr_cyc[k+1] - wr_cyc[k]), 32'd2);
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
